mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the unpipelined MIPS core. It sits directly downstream of the ALU control decoder and consumes the 6-bit R-type function code for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It owns the architectural HI/LO registers and runs a 32-step shift-add multiply or restoring divide. While an operation is in flight it asserts a busy/stall flag to the datapath.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. The iteration count equals WIDTH.
- `i_clk`  in  1  clock. All state changes on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  request. Sampled only while `o_busy`=0.
- `i_aluControl`  in  6  function code: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- `i_op1`  in  WIDTH  rs value (multiplicand / dividend / MTHI, MTLO source).
- `i_op2`  in  WIDTH  rt value (multiplier / divisor).
- `o_busy`  out  1  multi-cycle operation in flight; the core stalls on it.
- `o_done`  out  1  one-cycle pulse when an accepted operation has committed.
- `o_result`  out  WIDTH  combinational: HI when code = MFHI, LO when code = MFLO, else 0.
- `o_hi`, `o_lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States:
  - IDLE: accepts requests.
  - RUN: runs the WIDTH iterations.
  - FIX: applies sign correction and commits HI/LO.
- IDLE with `i_start`=1:
  - MULT, MULTU, DIV, DIVU: latch operands, clear the step counter, go to RUN. For signed codes, latch operand magnitudes (two's-complement negate if the MSB is set) and record the sign flags.
  - MTHI / MTLO: write `i_op1` into HI / LO at this edge and stay in IDLE.
  - MFHI / MFLO: no state change.
  - Any other code: ignored.
- RUN, multiply: one shift-add per cycle over a 2·WIDTH-bit accumulator.
- RUN, divide: one restoring subtract-shift per cycle. Quotient builds in LO, remainder in HI.
- RUN exits to FIX after exactly WIDTH iterations (counter 0..WIDTH-1).
- FIX, MULT: if the operand signs differ, negate the 2·WIDTH-bit product.
- FIX, DIV: negate the quotient if the signs differ. The remainder takes the dividend's sign.
- FIX writes HI/LO and returns to IDLE.
- Divide by zero (`i_op2`=0, DIV or DIVU): full latency, then HI=`i_op1` (original value) and LO=all ones.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- MULT 0x80000000 × 0x80000000: HI=0x40000000, LO=0.
- `i_start` while `o_busy`=1 is ignored. HI/LO do not change and no extra `o_done` is produced.
- HI/LO hold their old values until FIX commits. No partial results appear on `o_hi`/`o_lo`.

## Timing
- Reset values, applied asynchronously: state IDLE, `o_busy`=0, `o_done`=0, HI=0, LO=0, counter 0. `o_result` follows combinationally.
- Mul/div accepted at edge N:
  - `o_busy`=1 after edge N.
  - Iterations on edges N+1 … N+WIDTH.
  - FIX commits HI/LO on edge N+WIDTH+1.
  - `o_busy` falls and `o_done`=1 for one cycle after edge N+WIDTH+1. Total latency is 33 clocks for WIDTH=32.
- MTHI/MTLO accepted at edge N: the register updates at edge N and `o_done`=1 for the single cycle after edge N. `o_busy` stays 0.
- MFHI/MFLO: zero latency and no `o_done`. The value reflects the committed HI/LO only.
- A new request is accepted on the same edge where `o_done` is high, provided `o_busy`=0.
- Reset asserted mid-operation aborts immediately. HI/LO clear to 0 and no `o_done` is issued.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `o_done` exactly 33 cycles after accept and `o_busy` high for 33 cycles.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → HI=0x1234, LO=0xFFFFFFFF after full latency.
- MTHI 0xA5A5A5A5, then MFHI → `o_result`=0xA5A5A5A5, with a one-cycle `o_done` after the MTHI. A MULT started mid-flight while busy is ignored and HI/LO stay unchanged.
- Reset asserted 10 cycles into a DIV → `o_busy`=0, HI=LO=0 immediately, no `o_done`. The next MULTU 6 × 7 gives LO=42.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the core datapath and the multiply/divide unit.
// The core drives the request side and reads the busy, done, result and HI/LO side.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [5:0]       i_aluControl;
   logic [WIDTH-1:0] i_op1;
   logic [WIDTH-1:0] i_op2;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_result;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;

   modport master (
      output i_start, i_aluControl, i_op1, i_op2,
      input  o_busy, o_done, o_result, o_hi, o_lo
   );

   modport slave (
      input  i_start, i_aluControl, i_op1, i_op2,
      output o_busy, o_done, o_result, o_hi, o_lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider that owns the MIPS HI/LO registers.
// Mul/div takes WIDTH+1 clocks under o_busy; MTHI/MTLO commit in the same cycle; MFHI/MFLO are combinational.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   mult_div_unit_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MFLO  = 6'b010010;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_next;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   orig_op1;
   logic [WIDTH-1:0]   hi, lo;
   logic               is_div, sign1, sign2, div_zero, done;

   logic               accept_md, write_hi, write_lo;
   logic               code_signed, code_div;
   logic [WIDTH-1:0]   mag1, mag2;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept_md  = 1'b0;
      write_hi   = 1'b0;
      write_lo   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_start) begin
               case (bus.i_aluControl)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     accept_md  = 1'b1;
                     state_next = RUN;
                  end
                  OP_MTHI: write_hi = 1'b1;
                  OP_MTLO: write_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN:     if (cnt == LAST) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign code_signed = (bus.i_aluControl == OP_MULT) || (bus.i_aluControl == OP_DIV);
   assign code_div    = (bus.i_aluControl == OP_DIV)  || (bus.i_aluControl == OP_DIVU);
   assign mag1 = (code_signed && bus.i_op1[WIDTH-1]) ? -bus.i_op1 : bus.i_op1;
   assign mag2 = (code_signed && bus.i_op2[WIDTH-1]) ? -bus.i_op2 : bus.i_op2;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   assign div_shift = acc[2*WIDTH-1:WIDTH-1];
   assign div_ge    = div_shift >= {1'b0, opnd};
   assign div_diff  = div_shift[WIDTH-1:0] - opnd;
   assign div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                             : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod_fix = (sign1 ^ sign2) ? -acc : acc;
   assign quo_fix  = (sign1 ^ sign2) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = sign1 ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         orig_op1 <= '0;
         hi       <= '0;
         lo       <= '0;
         is_div   <= 1'b0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         div_zero <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_md) begin
                  cnt      <= '0;
                  is_div   <= code_div;
                  sign1    <= code_signed & bus.i_op1[WIDTH-1];
                  sign2    <= code_signed & bus.i_op2[WIDTH-1];
                  div_zero <= code_div && (bus.i_op2 == '0);
                  orig_op1 <= bus.i_op1;
                  if (code_div) begin
                     acc  <= {{WIDTH{1'b0}}, mag1};
                     opnd <= mag2;
                  end else begin
                     acc  <= {{WIDTH{1'b0}}, mag2};
                     opnd <= mag1;
                  end
               end
               if (write_hi) hi <= bus.i_op1;
               if (write_lo) lo <= bus.i_op1;
               if (write_hi || write_lo) done <= 1'b1;
            end
            RUN: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               done <= 1'b1;
               if (!is_div) begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end else if (div_zero) begin
                  // Signed or not, a zero divisor reports the raw dividend and an all-ones quotient.
                  hi <= orig_op1;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_busy   = (state != IDLE);
   assign bus.o_done   = done;
   assign bus.o_hi     = hi;
   assign bus.o_lo     = lo;
   assign bus.o_result = (bus.i_aluControl == OP_MFHI) ? hi :
                         (bus.i_aluControl == OP_MFLO) ? lo : '0;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of mul/div results and latencies,
// plus hand sequences for MTHI/MFHI, ignored mid-flight requests and reset abort.
module tb_mult_div_unit;
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MFLO  = 6'b010010;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  code;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one mul/div and wait (bounded) for o_done; reports cycles to done and busy cycles seen.
   task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                         output int lat, output int bcnt);
      @(negedge clk);
      bus.i_start      = 1'b1;
      bus.i_aluControl = code;
      bus.i_op1        = a;
      bus.i_op2        = b;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      lat  = 0;
      bcnt = 0;
      while (lat < 40) begin
         if (bus.o_busy) bcnt++;
         if (inject && lat == 5) begin
            bus.i_start      = 1'b1;
            bus.i_aluControl = OP_MULT;
            bus.i_op1        = 32'd2;
            bus.i_op2        = 32'd3;
         end
         if (inject && lat == 6) bus.i_start = 1'b0;
         if (inject && lat == 10) begin
            chk("hi_held_in_flight", bus.o_hi, hold_hi);
            chk("lo_held_in_flight", bus.o_lo, hold_lo);
         end
         @(posedge clk);
         #1;
         lat++;
         if (bus.o_done) break;
      end
   endtask

   initial begin
      int lat, bcnt, pulses;
      errors = 0;
      checks = 0;

      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[3]  = '{OP_MULT,  32'd5,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC};
      vecs[4]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[6]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[8]  = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
      vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

      rst              = 1'b1;
      bus.i_start      = 1'b0;
      bus.i_aluControl = OP_MFHI;
      bus.i_op1        = '0;
      bus.i_op2        = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, bus.o_busy}, 32'd0);
      chk("reset_done", {31'd0, bus.o_done}, 32'd0);
      chk("reset_hi", bus.o_hi, 32'd0);
      chk("reset_lo", bus.o_lo, 32'd0);
      chk("reset_result", bus.o_result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].code, vecs[i].op1, vecs[i].op2, 1'b0, '0, '0, lat, bcnt);
         chk($sformatf("v%0d_latency", i), lat, 32'd33);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, 32'd33);
         chk($sformatf("v%0d_busy_at_done", i), {31'd0, bus.o_busy}, 32'd0);
         chk($sformatf("v%0d_hi", i), bus.o_hi, vecs[i].exp_hi);
         chk($sformatf("v%0d_lo", i), bus.o_lo, vecs[i].exp_lo);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_one_cycle", i), {31'd0, bus.o_done}, 32'd0);
      end

      bus.i_aluControl = OP_MFLO;
      #1;
      chk("mflo_result", bus.o_result, 32'hFFFFFFFF);
      bus.i_aluControl = OP_DIVU;
      #1;
      chk("result_other_code", bus.o_result, 32'd0);

      // MTHI then MFHI, then MTLO.
      @(negedge clk);
      bus.i_start      = 1'b1;
      bus.i_aluControl = OP_MTHI;
      bus.i_op1        = 32'hA5A5A5A5;
      @(posedge clk);
      #1;
      bus.i_start      = 1'b0;
      bus.i_aluControl = OP_MFHI;
      chk("mthi_done", {31'd0, bus.o_done}, 32'd1);
      chk("mthi_busy", {31'd0, bus.o_busy}, 32'd0);
      chk("mthi_hi", bus.o_hi, 32'hA5A5A5A5);
      #1;
      chk("mfhi_result", bus.o_result, 32'hA5A5A5A5);
      @(posedge clk);
      #1;
      chk("mthi_done_cleared", {31'd0, bus.o_done}, 32'd0);
      @(negedge clk);
      bus.i_start      = 1'b1;
      bus.i_aluControl = OP_MTLO;
      bus.i_op1        = 32'h5A5A0001;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      chk("mtlo_lo", bus.o_lo, 32'h5A5A0001);
      chk("mtlo_hi_kept", bus.o_hi, 32'hA5A5A5A5);

      // MULTU with a MULT request injected while busy.
      run_op(OP_MULTU, 32'd6, 32'd7, 1'b1, 32'hA5A5A5A5, 32'h5A5A0001, lat, bcnt);
      chk("inject_latency", lat, 32'd33);
      chk("inject_hi", bus.o_hi, 32'd0);
      chk("inject_lo", bus.o_lo, 32'd42);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.o_done) pulses++;
      end
      chk("inject_no_extra_done", pulses, 32'd0);
      chk("inject_idle", {31'd0, bus.o_busy}, 32'd0);

      // Reset ten cycles into a DIV.
      @(negedge clk);
      bus.i_start      = 1'b1;
      bus.i_aluControl = OP_DIV;
      bus.i_op1        = 32'd100;
      bus.i_op2        = 32'd7;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_reset_busy", {31'd0, bus.o_busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, bus.o_busy}, 32'd0);
      chk("abort_hi", bus.o_hi, 32'd0);
      chk("abort_lo", bus.o_lo, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.o_done) pulses++;
      end
      chk("abort_no_done", pulses, 32'd0);
      run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, '0, '0, lat, bcnt);
      chk("post_reset_latency", lat, 32'd33);
      chk("post_reset_lo", bus.o_lo, 32'd42);
      chk("post_reset_hi", bus.o_hi, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
